// File: rtl/aes_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_dec_pkg
// Description : Shared encodings and GF(2^8) helpers for the AES inverse
//               cipher round engine.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_dec_pkg;

    // Key length encodings as presented on the keylen port
    localparam logic [1:0] c_KEYLEN_128  = 2'b00;
    localparam logic [1:0] c_KEYLEN_192  = 2'b01;
    localparam logic [1:0] c_KEYLEN_256  = 2'b10;
    localparam logic [1:0] c_KEYLEN_RSVD = 2'b11;

    // Number of rounds per key length
    localparam logic [3:0] c_NR_128 = 4'd10;
    localparam logic [3:0] c_NR_192 = 4'd12;
    localparam logic [3:0] c_NR_256 = 4'd14;

    // Round engine state encodings
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_INIT = 2'd1;
    localparam logic [1:0] c_ST_SBOX = 2'd2;
    localparam logic [1:0] c_ST_MAIN = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_INIT = c_ST_INIT,
        ST_SBOX = c_ST_SBOX,
        ST_MAIN = c_ST_MAIN
    } state_t;

    // Round count for a key length; the reserved code never starts a run
    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        logic [3:0] nr;
        case (kl)
            c_KEYLEN_192: nr = c_NR_192;
            c_KEYLEN_256: nr = c_NR_256;
            default:      nr = c_NR_128;
        endcase
        return nr;
    endfunction

    // Constant multipliers in GF(2^8) with the AES polynomial
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm4(input logic [7:0] b);
        return gm2(gm2(b));
    endfunction

    function automatic logic [7:0] gm8(input logic [7:0] b);
        return gm2(gm4(b));
    endfunction

    function automatic logic [7:0] gm9(input logic [7:0] b);
        return gm8(b) ^ b;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] b);
        return gm8(b) ^ gm2(b) ^ b;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] b);
        return gm8(b) ^ gm4(b) ^ b;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] b);
        return gm8(b) ^ gm4(b) ^ gm2(b);
    endfunction

    // InvMixColumns on one column; byte 0 is the most significant
    function automatic logic [31:0] inv_mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm9(b3),
                gm9(b0)  ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
                gm13(b0) ^ gm9(b1)  ^ gm14(b2) ^ gm11(b3),
                gm11(b0) ^ gm13(b1) ^ gm9(b2)  ^ gm14(b3)};
    endfunction

    function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
        return {inv_mixw(s[127:96]), inv_mixw(s[95:64]),
                inv_mixw(s[63:32]),  inv_mixw(s[31:0])};
    endfunction

    // Row r rotates right by r columns; column c occupies bits [127-32c -: 32]
    function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + 4 - r) % 4) - 8*r -: 8];
            end
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_decipher_block_p_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_sbox_1
// Description : Four-byte AES inverse S-box. Computed as inverse affine map
//               followed by the multiplicative inverse in GF(2^8).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_sbox_1
    import aes_dec_pkg::*;
(
    input  logic [31:0] i_sword,
    output logic [31:0] o_sword
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gm2(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    assign o_sword = {inv_sbox(i_sword[31:24]), inv_sbox(i_sword[23:16]),
                      inv_sbox(i_sword[15:8]),  inv_sbox(i_sword[7:0])};

endmodule
`default_nettype wire

// File: rtl/aes_decipher_block_p.sv
`default_nettype none
// ============================================================================
// Module      : aes_decipher_block_p
// Description : Iterative AES inverse-cipher round engine, 128/192/256-bit
//               keys, SBOX_PAR inverse S-box words per cycle (1, 2 or 4).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_decipher_block_p
    import aes_dec_pkg::*;
#(
    parameter int SBOX_PAR             = 1,
    parameter bit RESET_BLOCK_ON_ABORT = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         abort,
    input  logic [1:0]   keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready,
    output logic         done,
    output logic         err
);

    // Index of the final S-box cycle of a round
    localparam logic [1:0] c_LAST = 2'(4 / SBOX_PAR - 1);

    state_t       r_state, w_state_nxt;
    logic [127:0] r_block, w_block_nxt;
    logic [3:0]   r_round, w_round_nxt;
    logic         r_ready, w_ready_nxt;
    logic         r_done,  w_done_nxt;
    logic         r_err,   w_err_nxt;
    logic [1:0]   r_sword_ctr, w_sword_ctr_nxt;
    logic [1:0]   r_keylen, w_keylen_nxt;

    logic [31:0]  w_words    [4];
    logic [31:0]  w_wb_words [4];
    logic [31:0]  w_sbox_in  [SBOX_PAR];
    logic [31:0]  w_sbox_out [SBOX_PAR];
    logic [1:0]   w_sel      [SBOX_PAR];
    logic [127:0] w_sbox_block;
    logic         w_last;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_word
            assign w_words[k] = r_block[127 - 32*k -: 32];
        end
        // Lane g handles word sword_ctr*SBOX_PAR + g; mod-4 wrap is harmless
        for (genvar g = 0; g < SBOX_PAR; g++) begin : g_sbox
            assign w_sel[g]     = r_sword_ctr * 2'(SBOX_PAR) + 2'(g);
            assign w_sbox_in[g] = w_words[w_sel[g]];
            aes_inv_sbox_1 u_sbox (
                .i_sword (w_sbox_in[g]),
                .o_sword (w_sbox_out[g])
            );
        end
    endgenerate

    assign w_last = (r_sword_ctr == c_LAST);

    // Splice the substituted words back into their slots of the state
    always_comb begin
        w_wb_words = w_words;
        for (int g = 0; g < SBOX_PAR; g++) begin
            w_wb_words[w_sel[g]] = w_sbox_out[g];
        end
        w_sbox_block = {w_wb_words[0], w_wb_words[1], w_wb_words[2], w_wb_words[3]};
    end

    // Next-state and datapath selection; abort overrides everything when busy
    always_comb begin
        w_state_nxt     = r_state;
        w_block_nxt     = r_block;
        w_round_nxt     = r_round;
        w_ready_nxt     = r_ready;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_sword_ctr_nxt = r_sword_ctr;
        w_keylen_nxt    = r_keylen;
        case (r_state)
            ST_IDLE: begin
                if (next && !abort) begin
                    if (keylen == c_KEYLEN_RSVD) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_keylen_nxt = keylen;
                        w_round_nxt  = nr_of(keylen);
                        w_ready_nxt  = 1'b0;
                        w_state_nxt  = ST_INIT;
                    end
                end
            end
            ST_INIT: begin
                w_block_nxt     = inv_shiftrows(block ^ round_key);
                w_round_nxt     = nr_of(r_keylen);
                w_sword_ctr_nxt = 2'd0;
                w_state_nxt     = ST_SBOX;
            end
            ST_SBOX: begin
                w_block_nxt     = w_sbox_block;
                w_sword_ctr_nxt = w_last ? 2'd0 : r_sword_ctr + 2'd1;
                if (w_last) begin
                    w_round_nxt = r_round - 4'd1;
                    w_state_nxt = ST_MAIN;
                end
            end
            ST_MAIN: begin
                if (r_round != 4'd0) begin
                    w_block_nxt = inv_shiftrows(inv_mixcolumns(r_block ^ round_key));
                    w_state_nxt = ST_SBOX;
                end else begin
                    w_block_nxt = r_block ^ round_key;
                    w_ready_nxt = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt     = ST_IDLE;
            w_ready_nxt     = 1'b1;
            w_done_nxt      = 1'b0;
            w_round_nxt     = 4'd0;
            w_sword_ctr_nxt = 2'd0;
            w_block_nxt     = RESET_BLOCK_ON_ABORT ? 128'd0 : r_block;
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_block     <= 128'd0;
            r_round     <= 4'd0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_sword_ctr <= 2'd0;
            r_keylen    <= c_KEYLEN_128;
        end else begin
            r_state     <= w_state_nxt;
            r_block     <= w_block_nxt;
            r_round     <= w_round_nxt;
            r_ready     <= w_ready_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_sword_ctr <= w_sword_ctr_nxt;
            r_keylen    <= w_keylen_nxt;
        end
    end

    assign round     = r_round;
    assign new_block = r_block;
    assign ready     = r_ready;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_decipher_block_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_decipher_block_p
// Description : Self-checking bench for aes_decipher_block_p with a byte-level
//               AES reference model and a behavioural key memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_decipher_block_p;

    localparam int c_PAR = 2;
    localparam int c_S   = 4 / c_PAR;

    localparam logic [255:0] c_K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] c_K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] c_K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] c_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] c_CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset, next, abort;
    logic [1:0]   keylen;
    logic [3:0]   round;
    logic [127:0] round_key, block, new_block;
    logic         ready, done, err;

    logic [127:0] rk [16];
    logic [7:0]   sb [256];
    logic [7:0]   isb [256];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]   kl;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           abort_at;
        int           poke_at;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    // Behavioural key memory: round key selected by the DUT's round index
    assign round_key = rk[round];

    aes_decipher_block_p #(.SBOX_PAR(c_PAR), .RESET_BLOCK_ON_ABORT(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .next      (next),
        .abort     (abort),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = 8'(x << 1) ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box tables from first principles: brute-force inverse plus affine map
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic int nr_for(input logic [1:0] kl);
        return (kl == 2'b00) ? 10 : (kl == 2'b01) ? 12 : 14;
    endfunction

    // FIPS-197 key expansion into the key memory
    task automatic expand_key(input logic [1:0] kl, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nr;
        nr = nr_for(kl);
        nk = nr - 6;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk[r] = '0;
        end
    endtask

    // Textbook inverse cipher on a 4x4 byte matrix, s[row][col]
    function automatic logic [127:0] ref_decrypt(input int nr, input logic [127:0] ct);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = ct[127 - 8*(4*c + r) -: 8] ^ rk[nr][127 - 8*(4*c + r) -: 8];
        for (int rnd = nr - 1; rnd >= 0; rnd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][(c + r) % 4] = s[r][c];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = isb[t[r][c]] ^ rk[rnd][127 - 8*(4*c + r) -: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[0][c]; a1 = s[1][c]; a2 = s[2][c]; a3 = s[3][c];
                    s[0][c] = gmul(a0, 14) ^ gmul(a1, 11) ^ gmul(a2, 13) ^ gmul(a3, 9);
                    s[1][c] = gmul(a0, 9)  ^ gmul(a1, 14) ^ gmul(a2, 11) ^ gmul(a3, 13);
                    s[2][c] = gmul(a0, 13) ^ gmul(a1, 9)  ^ gmul(a2, 14) ^ gmul(a3, 11);
                    s[3][c] = gmul(a0, 11) ^ gmul(a1, 13) ^ gmul(a2, 9)  ^ gmul(a3, 14);
                end
            end
        end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = s[r][c];
        return o;
    endfunction

    // One operation, entered and left #1 after a rising edge with the DUT idle.
    // abort_at/poke_at give the edge number (edge 0 samples next) or -1.
    task automatic run_op(input string tag, input logic [1:0] kl, input logic [255:0] key,
                          input logic [127:0] ct, input logic [127:0] exp_pt,
                          input int abort_at, input int poke_at);
        int  nr, lat_exp, n, bad_n;
        bit  seen_done;
        nr      = nr_for(kl);
        lat_exp = 1 + nr * (c_S + 1);
        expand_key(kl, key);
        next = 1'b1; keylen = kl; block = ct;
        @(posedge clk); #1;
        next = 1'b0;
        chk($sformatf("%s start round", tag), round, 128'(nr));
        chk($sformatf("%s start ready", tag), ready, 0);
        n = 0; bad_n = -1; seen_done = 1'b0;
        while (!seen_done && n < lat_exp + 8) begin
            n++;
            if (n == abort_at) abort = 1'b1;
            if (n == poke_at) begin next = 1'b1; keylen = kl ^ 2'b01; end
            if (n == poke_at + 1) begin next = 1'b1; keylen = 2'b11; end
            @(posedge clk); #1;
            abort = 1'b0; next = 1'b0; keylen = kl;
            if (n == 1) block = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (n == abort_at) break;
            if (done) seen_done = 1'b1;
            else if (round !== 4'(nr - n / (c_S + 1)) || ready !== 1'b0 || err !== 1'b0) begin
                if (bad_n < 0) bad_n = n;
            end
        end
        chk($sformatf("%s busy-phase first bad edge", tag), 128'(bad_n), 128'(-1));
        if (abort_at > 0) begin
            chk($sformatf("%s abort reached", tag), 128'(n), 128'(abort_at));
            chk($sformatf("%s abort done", tag), done, 0);
            chk($sformatf("%s abort ready", tag), ready, 1);
            chk($sformatf("%s abort round", tag), round, 0);
            chk($sformatf("%s abort new_block", tag), new_block, 0);
        end else begin
            chk($sformatf("%s latency", tag), seen_done ? 128'(n) : 128'(-1), 128'(lat_exp));
            chk($sformatf("%s plaintext", tag), new_block, exp_pt);
            chk($sformatf("%s ready at done", tag), ready, 1);
            @(posedge clk); #1;
            chk($sformatf("%s done width", tag), done, 0);
            chk($sformatf("%s ready after", tag), ready, 1);
            chk($sformatf("%s plaintext held", tag), new_block, exp_pt);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   r_kl;
        logic [255:0] r_key;
        logic [127:0] r_ct, r_pt;

        reset = 1'b1; next = 1'b0; abort = 1'b0; keylen = 2'b00; block = '0;
        for (int r = 0; r < 16; r++) rk[r] = '0;
        build_tables();
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", ready, 1);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset round", round, 0);
        chk("reset new_block", new_block, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vectors: known answers, aborts, restarts and mid-op pokes
        tbl[0] = '{2'b00, c_K128, c_CT128, c_PT, -1, -1};
        tbl[1] = '{2'b01, c_K192, c_CT192, c_PT, -1, -1};
        tbl[2] = '{2'b10, c_K256, c_CT256, c_PT, -1, -1};
        tbl[3] = '{2'b00, c_K128, c_CT128, c_PT, 20, -1};
        tbl[4] = '{2'b00, c_K128, c_CT128, c_PT, -1, -1};
        tbl[5] = '{2'b00, c_K128, c_CT128, c_PT, 1 + 10 * (c_S + 1), -1};
        tbl[6] = '{2'b00, c_K128, c_CT128, c_PT, -1, 10};
        tbl[7] = '{2'b10, c_K256, c_CT256, c_PT, -1, 30};
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].kl, tbl[i].key, tbl[i].ct, tbl[i].pt,
                   tbl[i].abort_at, tbl[i].poke_at);
        end

        // Reserved key length: err pulse, stay idle, then a normal start
        next = 1'b1; keylen = 2'b11;
        @(posedge clk); #1;
        next = 1'b0; keylen = 2'b00;
        chk("rsvd err", err, 1);
        chk("rsvd ready", ready, 1);
        chk("rsvd round", round, 0);
        @(posedge clk); #1;
        chk("rsvd err width", err, 0);
        chk("rsvd still idle", ready, 1);
        run_op("after_rsvd", 2'b00, c_K128, c_CT128, c_PT, -1, -1);

        // abort together with next in IDLE: no start and no err
        abort = 1'b1; next = 1'b1; keylen = 2'b00;
        @(posedge clk); #1;
        keylen = 2'b11;
        chk("idle abort+next ready", ready, 1);
        chk("idle abort+next round", round, 0);
        @(posedge clk); #1;
        abort = 1'b0; next = 1'b0; keylen = 2'b00;
        chk("idle abort+rsvd err", err, 0);
        chk("idle abort+rsvd ready", ready, 1);

        // Asynchronous reset while in SBOX, observed between clock edges
        expand_key(2'b00, c_K128);
        next = 1'b1; keylen = 2'b00; block = c_CT128;
        @(posedge clk); #1;
        next = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("async reset ready", ready, 1);
        chk("async reset round", round, 0);
        chk("async reset new_block", new_block, 0);
        chk("async reset done", done, 0);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("after reset idle", ready, 1);
        run_op("after_reset", 2'b00, c_K128, c_CT128, c_PT, -1, -1);

        // Random keys and ciphertexts against the reference model
        for (int i = 0; i < 6; i++) begin
            r_kl  = 2'($urandom_range(0, 2));
            r_key = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
            r_ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand_key(r_kl, r_key);
            r_pt  = ref_decrypt(nr_for(r_kl), r_ct);
            run_op($sformatf("rand%0d", i), r_kl, r_key, r_ct, r_pt, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
